truth_table_sweeper: RTL and testbench

//  Drives every 4-bit input code into a 4-in/4-out logic circuit under test, waits a settle time,

---
 rtl/tt_sweep_pkg.sv | 26 ++
 rtl/tt_sync.sv | 34 +++
 rtl/truth_table_sweeper.sv | 144 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tt_sweep_pkg;

  localparam int CODE_W  = 4;
  localparam int N_CODES = 16;

  // Expected CUT response nibble for code i lives at bits [4*i +: 4].
  localparam logic [CODE_W*N_CODES-1:0] EXPECTED_DEFAULT = 64'h1F1B_0E0A_1D19_0C08;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    REPORT,
    FINISH
  } state_e;

  // Look up the expected response nibble for one input code.
  function automatic logic [CODE_W-1:0] exp_nibble(
    input logic [CODE_W*N_CODES-1:0] table_i,
    input logic [CODE_W-1:0]         code_i
  );
    return table_i[CODE_W*code_i +: CODE_W];
  endfunction

endpackage

// File: rtl/tt_sync.sv
// Per-bit flop synchroniser that brings the asynchronous CUT response into
// the clk domain. Latency is STAGES clock edges.
module tt_sync
  import tt_sweep_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int WIDTH  = CODE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // Shift the raw response through the synchroniser chain.
  // NOTE: every flop of the chain is reset so a sample taken straight after
  // reset is a defined 0 rather than X; non-blocking assignment keeps the
  // stages shifting as a true pipeline instead of collapsing into one flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int s = 1; s < STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps codes 0..15 into a 4-in/4-out circuit under test, waits for the
// response to settle, samples it and streams one result beat per code.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int                          SETTLE_CYCLES = 8,
  parameter int                          SYNC_STAGES   = 2,
  parameter logic [CODE_W*N_CODES-1:0]   EXPECTED      = EXPECTED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic [CODE_W-1:0] stim_o,
  input  logic [CODE_W-1:0] resp_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [CODE_W-1:0] res_code_o,
  output logic [CODE_W-1:0] res_data_o,
  output logic              res_match_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [4:0]        mismatch_cnt_o
);

  // Counter is wide enough for the largest legal settle + synchroniser span.
  localparam int              CNT_W       = 9;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES + SYNC_STAGES - 1);
  localparam logic [CODE_W-1:0] LAST_CODE  = CODE_W'(N_CODES - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CODE_W-1:0]  stim_q;
  logic               busy_q;
  logic               res_valid_q;
  logic [CODE_W-1:0]  res_code_q;
  logic [CODE_W-1:0]  res_data_q;
  logic               res_match_q;
  logic               done_q;
  logic               pass_q;
  logic [4:0]         mismatch_cnt_q;

  logic [CODE_W-1:0]  resp_sync;
  logic               match_d;

  tt_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (CODE_W)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (resp_i),
    .sync_o  (resp_sync)
  );

  // Compare the synchronised response against the expected nibble for stim.
  // NOTE: the default assignment first guarantees no latch is inferred.
  always_comb begin
    match_d = 1'b0;
    if (resp_sync == exp_nibble(EXPECTED, stim_q)) begin
      match_d = 1'b1;
    end
  end

  // Sweep FSM with the settle counter, stimulus, result and summary registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stim_q         <= '0;
      busy_q         <= 1'b0;
      res_valid_q    <= 1'b0;
      res_code_q     <= '0;
      res_data_q     <= '0;
      res_match_q    <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      mismatch_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_q         <= 1'b1;
            stim_q         <= '0;
            mismatch_cnt_q <= '0;
            pass_q         <= 1'b0;
            cnt_q          <= '0;
            state_q        <= SETTLE;
          end
        end
        SETTLE: begin
          // Settle time counts from the stim change through the synchroniser.
          if (cnt_q == SETTLE_LAST) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SAMPLE: begin
          res_code_q     <= stim_q;
          res_data_q     <= resp_sync;
          res_match_q    <= match_d;
          mismatch_cnt_q <= mismatch_cnt_q + {4'b0, ~match_d};
          res_valid_q    <= 1'b1;
          state_q        <= REPORT;
        end
        REPORT: begin
          // Beat fields stay frozen until the logger accepts them.
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            if (stim_q == LAST_CODE) begin
              done_q  <= 1'b1;
              pass_q  <= (mismatch_cnt_q == 5'd0);
              state_q <= FINISH;
            end else begin
              stim_q  <= stim_q + 1'b1;
              cnt_q   <= '0;
              state_q <= SETTLE;
            end
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign stim_o         = stim_q;
  assign res_valid_o    = res_valid_q;
  assign res_code_o     = res_code_q;
  assign res_data_o     = res_data_q;
  assign res_match_o    = res_match_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign mismatch_cnt_o = mismatch_cnt_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: CUT model with selectable faults
// and delay, ready patterns, start/reset interference.
module tb_truth_table_sweeper;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic       busy_o;
  logic [3:0] stim_o;
  logic [3:0] resp_i;
  logic       res_valid_o;
  logic       res_ready_i;
  logic [3:0] res_code_o;
  logic [3:0] res_data_o;
  logic       res_match_o;
  logic       done_o;
  logic       pass_o;
  logic [4:0] mismatch_cnt_o;

  truth_table_sweeper dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .busy_o         (busy_o),
    .stim_o         (stim_o),
    .resp_i         (resp_i),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready_i),
    .res_code_o     (res_code_o),
    .res_data_o     (res_data_o),
    .res_match_o    (res_match_o),
    .done_o         (done_o),
    .pass_o         (pass_o),
    .mismatch_cnt_o (mismatch_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected response per code, written out code by code.
  logic [3:0] exp_tab [16] = '{4'h8, 4'h0, 4'hC, 4'h0, 4'h9, 4'h1, 4'hD, 4'h1,
                               4'hA, 4'h0, 4'hE, 4'h0, 4'hB, 4'h1, 4'hF, 4'h1};

  // CUT model: 0 ideal, 1 code 6 forced to C, 2 stuck at 0; optional delay.
  int cut_mode = 0;
  int cut_dly  = 0;
  logic [15:0][3:0] hist_q = '0;
  logic [3:0] cut_code;

  always @(posedge clk) hist_q <= {hist_q[14:0], stim_o};

  always @* begin
    cut_code = (cut_dly == 0) ? stim_o : hist_q[cut_dly-1];
    case (cut_mode)
      1:       resp_i = (cut_code == 4'h6) ? 4'hC : exp_tab[cut_code];
      2:       resp_i = 4'h0;
      default: resp_i = exp_tab[cut_code];
    endcase
  end

  function automatic logic [3:0] model_data(input int mode, input logic [3:0] code);
    case (mode)
      1:       return (code == 4'h6) ? 4'hC : exp_tab[code];
      2:       return 4'h0;
      default: return exp_tab[code];
    endcase
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-sweep observations.
  int         beat_cnt, order_err, data_err, match_err, stable_err, stim_err;
  int         busy_cycles, stall;
  bit         done_seen, pass_seen;
  logic [4:0] mm_seen;
  logic [3:0] data_log [16];
  logic       match_log [16];

  task automatic run_sweep(input int mode, input int dly, input int rmode, input bit poke);
    bit         prev_valid, prev_xfer, poked;
    logic [8:0] prev_fields;
    cut_mode = mode; cut_dly = dly;
    beat_cnt = 0; order_err = 0; data_err = 0; match_err = 0; stable_err = 0;
    stim_err = 0; busy_cycles = 0; stall = 0; done_seen = 0; pass_seen = 0; mm_seen = '0;
    prev_valid = 0; prev_xfer = 0; poked = 0; prev_fields = '0;
    for (int i = 0; i < 16; i++) begin data_log[i] = 'x; match_log[i] = 1'bx; end
    @(negedge clk);
    start_i = 1'b1;
    for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (poke && beat_cnt == 5 && !poked) begin
        start_i = 1'b1;
        poked = 1;
      end
      case (rmode)
        1: res_ready_i = 1'($urandom_range(0, 1));
        2: begin
          if (res_valid_o && res_code_o == 4'h3 && stall < 50) begin
            res_ready_i = 1'b0;
            stall++;
            if (stim_o != 4'h3) stim_err++;
          end else begin
            res_ready_i = 1'b1;
          end
        end
        default: res_ready_i = 1'b1;
      endcase
      if (busy_o) busy_cycles++;
      if (prev_valid && !prev_xfer) begin
        if (!res_valid_o || {res_code_o, res_data_o, res_match_o} != prev_fields) stable_err++;
      end
      if (res_valid_o && res_ready_i) begin
        if (res_code_o != 4'(beat_cnt)) order_err++;
        if (res_match_o != (res_data_o == exp_tab[res_code_o])) match_err++;
        if (dly == 0 && res_data_o != model_data(mode, res_code_o)) data_err++;
        data_log[res_code_o]  = res_data_o;
        match_log[res_code_o] = res_match_o;
        beat_cnt++;
      end
      prev_valid  = res_valid_o;
      prev_xfer   = res_valid_o && res_ready_i;
      prev_fields = {res_code_o, res_data_o, res_match_o};
      if (done_o) begin
        done_seen = 1;
        pass_seen = pass_o;
        mm_seen   = mismatch_cnt_o;
      end
    end
    res_ready_i = 1'b1;
    start_i = 1'b0;
  endtask

  initial begin
    bit wait_ok;
    int bad;
    rst = 1'b0; start_i = 1'b0; res_ready_i = 1'b1;
    #1 rst = 1'b1;
    #20;
    check("reset_outputs", {busy_o, stim_o, res_valid_o, res_code_o, res_data_o,
                            res_match_o, done_o, pass_o, mismatch_cnt_o}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: ideal CUT, ready always high.
    run_sweep(0, 0, 0, 0);
    check("t1_done", done_seen, 1);
    check("t1_beats", beat_cnt, 16);
    check("t1_order", order_err, 0);
    check("t1_data", data_err, 0);
    check("t1_match", match_err, 0);
    check("t1_all_match", {match_log[0], match_log[6], match_log[15]}, 3'b111);
    check("t1_busy_cycles", busy_cycles, 16 * (8 + 2 + 2) + 1);
    check("t1_pass", pass_seen, 1);
    check("t1_mm", mm_seen, 0);
    @(negedge clk);
    check("t1_busy_drop", busy_o, 0);
    check("t1_done_pulse", done_o, 0);
    repeat (5) @(negedge clk);
    check("t1_pass_hold", {pass_o, mismatch_cnt_o}, 6'b1_00000);

    // 2: code 6 forced to C.
    run_sweep(1, 0, 0, 0);
    check("t2_done", done_seen, 1);
    check("t2_data6", data_log[6], 4'hC);
    check("t2_match6", match_log[6], 0);
    check("t2_data", data_err, 0);
    check("t2_pass", pass_seen, 0);
    check("t2_mm", mm_seen, 1);
    check("t2_mm_hold", mismatch_cnt_o, 1);

    // 3: CUT delay inside / beyond the settle window.
    run_sweep(0, 7, 0, 0);
    check("t3_slow_ok_pass", pass_seen, 1);
    check("t3_slow_ok_mm", mm_seen, 0);
    run_sweep(0, 11, 0, 0);
    check("t3_too_slow_done", done_seen, 1);
    check("t3_too_slow_pass", pass_seen, 0);
    check("t3_too_slow_mm_nz", mm_seen != 0, 1);
    check("t3_too_slow_match", match_err, 0);
    check("t3_too_slow_beats", beat_cnt, 16);

    // 4: random ready, then a 50-cycle stall at code 3.
    run_sweep(0, 0, 1, 0);
    check("t4_rand_beats", beat_cnt, 16);
    check("t4_rand_order", order_err, 0);
    check("t4_rand_stable", stable_err, 0);
    check("t4_rand_pass", pass_seen, 1);
    run_sweep(0, 0, 2, 0);
    check("t4_stall_len", stall, 50);
    check("t4_stall_stim", stim_err, 0);
    check("t4_stall_stable", stable_err, 0);
    check("t4_stall_beats", beat_cnt, 16);
    check("t4_stall_order", order_err, 0);

    // 5: start while busy is ignored.
    run_sweep(0, 0, 0, 1);
    check("t5_poke_beats", beat_cnt, 16);
    check("t5_poke_order", order_err, 0);
    check("t5_poke_busy", busy_cycles, 193);
    check("t5_poke_pass", pass_seen, 1);

    // 5: reset at code 9 discards the sweep.
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    wait_ok = 0;
    for (int cyc = 0; cyc < 500 && !wait_ok; cyc++) begin
      @(negedge clk);
      if (stim_o == 4'h9) wait_ok = 1;
    end
    check("t5_reach_code9", wait_ok, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_outputs", {busy_o, stim_o, res_valid_o, res_code_o, res_data_o,
                             res_match_o, done_o, pass_o, mismatch_cnt_o}, 0);
    @(negedge clk) rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o || busy_o || res_valid_o) bad++;
    end
    check("t5_no_done_after_rst", bad, 0);
    run_sweep(0, 0, 0, 0);
    check("t5_clean_beats", beat_cnt, 16);
    check("t5_clean_order", order_err, 0);
    check("t5_clean_pass", pass_seen, 1);

    // 6: CUT stuck at 0; only codes 1,3,9,B match.
    run_sweep(2, 0, 0, 0);
    check("t6_data", data_err, 0);
    check("t6_match1", match_log[1], 1);
    check("t6_match0", match_log[0], 0);
    check("t6_pass", pass_seen, 0);
    check("t6_mm", mm_seen, 12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
